fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-low; see Reset.
REQ-004 freeze  in  1  downstream IF/ID register holding; no instruction may be delivered.
REQ-005 branchTaken  in  1  redirect request from later stage; wins over freeze.
REQ-006 branchAddr  in  32  redirect target, sampled only when branchTaken=1.
REQ-007 memReq  out  1  instruction-memory request; combinational from state.
REQ-008 memAddr  out  32  fetch address; stable while memReq=1 and memReady=0.
REQ-009 memReady  in  1  one-cycle pulse; memData valid for the outstanding memAddr.
REQ-010 memData  in  32  fetched instruction word.
REQ-011 PC  out  32  registered; fetched address + 4, feeds IF/ID PCIn.
REQ-012 instruction  out  32  registered; fetched word or 0 (bubble), feeds IF/ID instructionIn.
REQ-013 instrValid  out  1  registered; 1 for exactly the cycle PC/instruction carry a new delivery.
REQ-014 fetchCount, stallCount  out  32 each  performance counters (see Configuration).

Function
REQ-015 The block SHALL implement states FETCH, HOLD, DROP, plus registers pcReg, redirReg, bufInstr.
REQ-016 FETCH: memReq=1, memAddr=pcReg. DROP: memReq=1, memAddr=pcReg. HOLD: memReq=0.
REQ-017 FETCH, memReady=1, branchTaken=1: data SHALL be discarded, pcReg<=branchAddr, stay FETCH.
REQ-018 FETCH, memReady=1, branchTaken=0, freeze=1: bufInstr<=memData, go HOLD.
REQ-019 FETCH, memReady=1, branchTaken=0, freeze=0: deliver (REQ-024), pcReg<=pcReg+4, stay FETCH.
REQ-020 FETCH, memReady=0, branchTaken=1: redirReg<=branchAddr, go DROP; memAddr SHALL NOT change.
REQ-021 DROP: on memReady, discard data, pcReg<=redirReg, go FETCH; a further branchTaken in DROP SHALL overwrite redirReg (last redirect wins).
REQ-022 HOLD, branchTaken=1: discard bufInstr, pcReg<=branchAddr, go FETCH.
REQ-023 HOLD, branchTaken=0, freeze=0: deliver bufInstr, pcReg<=pcReg+4, go FETCH; freeze=1: stay HOLD.
REQ-024 Delivery: next cycle instruction=word, PC=pcReg+4, instrValid=1; latency memReady->instrValid is 1 cycle when freeze=0.
REQ-025 Non-delivery cycle with freeze=0: instruction<=0, PC<=0, instrValid<=0 (bubble); with freeze=1: PC/instruction hold, instrValid<=0.
REQ-026 All address arithmetic SHALL be 32-bit modulo 2^32; pcReg=32'hFFFF_FFFC advances to 0.
REQ-027 Each memReady SHALL complete the outstanding request; memReady with memReq=0 SHALL be ignored.

Reset
REQ-028 rst=0 SHALL asynchronously force: state=FETCH, pcReg=RESET_PC, redirReg=0, bufInstr=0, PC=0, instruction=0, instrValid=0, counters=0.
REQ-029 Reset mid-request SHALL abandon the outstanding fetch; first memAddr after release SHALL be RESET_PC.

Configuration
REQ-030 Macro FETCH_PERF_EN: defined -> fetchCount increments per delivery, stallCount increments per cycle in FETCH/DROP/HOLD without delivery, both wrap at 2^32.
REQ-031 Without FETCH_PERF_EN: fetchCount and stallCount SHALL be constant 0, no counter flops; all other behaviour identical.

Verification
REQ-032 Reset release, memReady every cycle, freeze=0 -> memAddr 0,4,8; PC outputs 4,8,12 one cycle after each memReady, instrValid=1.
REQ-033 memReady with freeze=1 for 3 cycles, memData=32'h1234_5678 -> HOLD, memReq=0, no delivery; freeze drop -> instruction=32'h1234_5678, PC=pcReg+4 next cycle.
REQ-034 branchTaken, branchAddr=32'h100 while memAddr=8 pending 2 cycles -> memAddr stays 8, returning word discarded, next memAddr=32'h100.
REQ-035 branchTaken same cycle as memReady and freeze=1 -> data discarded, next memAddr=branchAddr, no HOLD.
REQ-036 rst=0 pulse mid-DROP -> outputs 0 immediately without clk edge; after release memAddr=RESET_PC.
REQ-037 FETCH_PERF_EN defined, 5 deliveries and 3 frozen cycles -> fetchCount=5, stallCount=3; undefined -> both 0.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding memory request, freeze holding, branch redirect.
// Optional performance counters are enabled by defining FETCH_PERF_EN.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  localparam int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            freeze,
  input  logic            branchTaken,
  input  logic [XLEN-1:0] branchAddr,
  output logic            memReq,
  output logic [XLEN-1:0] memAddr,
  input  logic            memReady,
  input  logic [XLEN-1:0] memData,
  output logic [XLEN-1:0] PC,
  output logic [XLEN-1:0] instruction,
  output logic            instrValid,
  output logic [XLEN-1:0] fetchCount,
  output logic [XLEN-1:0] stallCount
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_HOLD  = 2'd1,
    S_DROP  = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] redir_q, redir_d;
  logic [XLEN-1:0] buf_q, buf_d;
  logic [XLEN-1:0] pc_out_q, pc_out_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic            valid_q, valid_d;
  logic            deliver;
  logic [XLEN-1:0] deliver_word;
  logic [XLEN-1:0] pc_inc;

  assign pc_inc = pc_q + XLEN'(4);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_FETCH;
    else      state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: begin
        if (memReady) begin
          if (!branchTaken && freeze) state_d = S_HOLD;
        end else if (branchTaken) begin
          state_d = S_DROP;
        end
      end
      S_DROP:  if (memReady) state_d = S_FETCH;
      S_HOLD:  if (branchTaken || !freeze) state_d = S_FETCH;
      default: state_d = S_FETCH;
    endcase
  end

  // Memory interface and datapath next values
  always_comb begin
    memReq       = (state_q != S_HOLD);
    memAddr      = pc_q;
    pc_d         = pc_q;
    redir_d      = redir_q;
    buf_d        = buf_q;
    deliver      = 1'b0;
    deliver_word = buf_q;
    case (state_q)
      S_FETCH: begin
        if (memReady) begin
          if (branchTaken) begin
            pc_d = branchAddr;
          end else if (freeze) begin
            buf_d = memData;
          end else begin
            deliver      = 1'b1;
            deliver_word = memData;
          end
        end else if (branchTaken) begin
          redir_d = branchAddr;
        end
      end
      // A redirect arriving together with the returning word is the latest one.
      S_DROP: begin
        if (memReady)         pc_d    = branchTaken ? branchAddr : redir_q;
        else if (branchTaken) redir_d = branchAddr;
      end
      S_HOLD: begin
        if (branchTaken)  pc_d    = branchAddr;
        else if (!freeze) deliver = 1'b1;
      end
      default: ;
    endcase
    if (deliver) pc_d = pc_inc;

    pc_out_d = pc_out_q;
    instr_d  = instr_q;
    valid_d  = 1'b0;
    if (deliver) begin
      pc_out_d = pc_inc;
      instr_d  = deliver_word;
      valid_d  = 1'b1;
    end else if (!freeze) begin
      pc_out_d = '0;
      instr_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q     <= RESET_PC;
      redir_q  <= '0;
      buf_q    <= '0;
      pc_out_q <= '0;
      instr_q  <= '0;
      valid_q  <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      redir_q  <= redir_d;
      buf_q    <= buf_d;
      pc_out_q <= pc_out_d;
      instr_q  <= instr_d;
      valid_q  <= valid_d;
    end
  end

  assign PC          = pc_out_q;
  assign instruction = instr_q;
  assign instrValid  = valid_q;

`ifdef FETCH_PERF_EN
  logic [XLEN-1:0] fetch_cnt_q, stall_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else if (deliver) begin
      fetch_cnt_q <= fetch_cnt_q + XLEN'(1);
    end else begin
      stall_cnt_q <= stall_cnt_q + XLEN'(1);
    end
  end

  assign fetchCount = fetch_cnt_q;
  assign stallCount = stall_cnt_q;
`else
  assign fetchCount = '0;
  assign stallCount = '0;
`endif

endmodule
